// File: rtl/link_init_ctrl.sv
// link_init_ctrl
//   Link initialisation state machine with transmit-credit accounting.
//   Walks ERROR_RESET -> ERROR_WAIT -> READY -> STARTED -> CONNECTING -> RUN,
//   dropping back to ERROR_RESET on any error condition. While CONNECTING or
//   RUN, each received FCT grants 8 credits and each sent data character
//   consumes one; overflowing 56 credits is a link error.
//
// Ports
//   clk, rst_n      : clock (rising edge), asynchronous active-low reset
//   link_start      : level, request to bring the link up
//   link_disable    : level, forces the link down
//   rx_got_null     : pulse, NULL received
//   rx_got_fct      : pulse, FCT received
//   rx_got_nchar    : pulse, data character received
//   rx_err          : receiver error (parity/escape/disconnect)
//   tx_char_sent    : pulse, transmitter consumed a data character
//   rx_en, tx_en    : receiver / transmitter enables
//   tx_fct_ok       : transmitter may send FCTs
//   tx_data_ok      : transmitter may send a data character
//   link_up         : high in RUN
//   state           : current state code (0..5)
//   tx_credit       : outstanding transmit credit (0..56)
//   err_credit      : one-cycle pulse on credit overflow
module link_init_ctrl #(
  parameter int T_RESET   = 64,
  parameter int T_WAIT    = 128,
  parameter int T_TIMEOUT = 128
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_start,
  input  logic       link_disable,
  input  logic       rx_got_null,
  input  logic       rx_got_fct,
  input  logic       rx_got_nchar,
  input  logic       rx_err,
  input  logic       tx_char_sent,
  output logic       rx_en,
  output logic       tx_en,
  output logic       tx_fct_ok,
  output logic       tx_data_ok,
  output logic       link_up,
  output logic [2:0] state,
  output logic [5:0] tx_credit,
  output logic       err_credit
);

  localparam int TMAX0 = (T_RESET > T_WAIT) ? T_RESET : T_WAIT;
  localparam int TMAX  = (TMAX0 > T_TIMEOUT) ? TMAX0 : T_TIMEOUT;
  localparam int TW    = $clog2(TMAX + 1);

  localparam logic [TW-1:0] RESET_LAST   = TW'(T_RESET - 1);
  localparam logic [TW-1:0] WAIT_LAST    = TW'(T_WAIT - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(T_TIMEOUT - 1);

  localparam logic [6:0] CREDIT_MAX = 7'd56;

  typedef enum logic [2:0] {
    ERROR_RESET = 3'd0,
    ERROR_WAIT  = 3'd1,
    READY       = 3'd2,
    STARTED     = 3'd3,
    CONNECTING  = 3'd4,
    RUN         = 3'd5
  } state_t;

  state_t          curState;
  state_t          nextState;
  logic [TW-1:0]   timer;
  logic [5:0]      creditReg;
  logic            errCreditReg;

  logic [6:0]      creditSum;
  logic            creditActive;
  logic            creditOvf;
  logic            rxProtoErr;

  // Candidate credit value for this cycle; a sent character only consumes
  // credit when there is some, so the sum never goes negative.
  always_comb begin
    creditSum = {1'b0, creditReg};
    if (rx_got_fct) begin
      creditSum = creditSum + 7'd8;
    end
    if (tx_char_sent && (creditReg != '0)) begin
      creditSum = creditSum - 7'd1;
    end
  end

  assign creditActive = (curState == CONNECTING) || (curState == RUN);
  assign creditOvf    = creditActive && (creditSum > CREDIT_MAX);
  assign rxProtoErr   = rx_err || rx_got_fct || rx_got_nchar;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      curState <= ERROR_RESET;
    end else begin
      curState <= nextState;
    end
  end

  // Next-state logic: error exits are tested before forward moves.
  always_comb begin
    nextState = curState;
    unique case (curState)
      ERROR_RESET: begin
        if (timer == RESET_LAST) nextState = ERROR_WAIT;
      end
      ERROR_WAIT: begin
        if (rxProtoErr)              nextState = ERROR_RESET;
        else if (timer == WAIT_LAST) nextState = READY;
      end
      READY: begin
        if (rxProtoErr)                        nextState = ERROR_RESET;
        else if (link_start && !link_disable)  nextState = STARTED;
      end
      STARTED: begin
        if (rxProtoErr || link_disable || (timer == TIMEOUT_LAST))
          nextState = ERROR_RESET;
        else if (rx_got_null)
          nextState = CONNECTING;
      end
      CONNECTING: begin
        if (rx_err || rx_got_nchar || link_disable || creditOvf ||
            (timer == TIMEOUT_LAST))
          nextState = ERROR_RESET;
        else if (rx_got_fct)
          nextState = RUN;
      end
      RUN: begin
        if (rx_err || link_disable || creditOvf) nextState = ERROR_RESET;
      end
      default: nextState = ERROR_RESET;
    endcase
  end

  // Outputs decoded from registered state and credit only.
  always_comb begin
    rx_en      = 1'b0;
    tx_en      = 1'b0;
    tx_fct_ok  = 1'b0;
    tx_data_ok = 1'b0;
    link_up    = 1'b0;
    unique case (curState)
      ERROR_RESET: ;
      ERROR_WAIT, READY: begin
        rx_en = 1'b1;
      end
      STARTED: begin
        rx_en = 1'b1;
        tx_en = 1'b1;
      end
      CONNECTING: begin
        rx_en     = 1'b1;
        tx_en     = 1'b1;
        tx_fct_ok = 1'b1;
      end
      RUN: begin
        rx_en      = 1'b1;
        tx_en      = 1'b1;
        tx_fct_ok  = 1'b1;
        link_up    = 1'b1;
        tx_data_ok = (creditReg != '0);
      end
      default: ;
    endcase
  end

  // Per-state cycle timer: zero on every state change, else counts up.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (nextState != curState) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end

  // Credit register. An overflowing update is never taken; the overflow also
  // sends the FSM to ERROR_RESET, whose entry clears the credit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      creditReg    <= '0;
      errCreditReg <= 1'b0;
    end else begin
      errCreditReg <= creditOvf;
      if (nextState == ERROR_RESET) begin
        creditReg <= '0;
      end else if (creditActive && !creditOvf) begin
        creditReg <= creditSum[5:0];
      end
    end
  end

  assign state      = curState;
  assign tx_credit  = creditReg;
  assign err_credit = errCreditReg;

endmodule
